// File: rtl/reg_file_dual_wr_if.sv
// Bus bundle for reg_file_dual_wr: two read ports, two write ports and clear.
// master : drives enables/addresses/write data/clear, receives read results.
// slave  : the register file side.
interface reg_file_dual_wr_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  clear;

    logic                  r0en;
    logic [ADDR_WIDTH-1:0] r0addr;
    logic [DATA_WIDTH-1:0] r0data;
    logic                  r0valid;

    logic                  r1en;
    logic [ADDR_WIDTH-1:0] r1addr;
    logic [DATA_WIDTH-1:0] r1data;
    logic                  r1valid;

    logic                  w0ena;
    logic [ADDR_WIDTH-1:0] w0addr;
    logic [DATA_WIDTH-1:0] w0data;

    logic                  w1ena;
    logic [ADDR_WIDTH-1:0] w1addr;
    logic [DATA_WIDTH-1:0] w1data;

    modport master (
        output clear,
        output r0en, r0addr, input r0data, r0valid,
        output r1en, r1addr, input r1data, r1valid,
        output w0ena, w0addr, w0data,
        output w1ena, w1addr, w1data
    );

    modport slave (
        input  clear,
        input  r0en, r0addr, output r0data, r0valid,
        input  r1en, r1addr, output r1data, r1valid,
        input  w0ena, w0addr, w0data,
        input  w1ena, w1addr, w1data
    );
endinterface

// File: rtl/reg_file_dual_wr.sv
// Dual-write, dual-read register file with per-entry valid bits.
// Reads are registered (1-cycle latency) and forward same-cycle writes;
// w1 beats w0 on an address collision; clear drops all valid bits except
// entries written in the same cycle.
// Ports: clk, reset (synchronous, active-high), bus (reg_file_dual_wr_if.slave).
// Optional: define REG_FILE_ZERO_REG_EN to hardwire entry 0 to data 0, valid 1.
module reg_file_dual_wr #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic               clk,
    input  logic               reset,
    reg_file_dual_wr_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      valid;

    logic                  w0_we_c;
    logic                  w1_we_c;
    logic [DATA_WIDTH:0]   r0_next_c;
    logic [DATA_WIDTH:0]   r1_next_c;

    // Effective write enables; entry 0 is read-only when hardwired.
    always_comb begin
        w0_we_c = bus.w0ena;
        w1_we_c = bus.w1ena;
`ifdef REG_FILE_ZERO_REG_EN
        if (bus.w0addr == ADDR_WIDTH'(0)) w0_we_c = 1'b0;
        if (bus.w1addr == ADDR_WIDTH'(0)) w1_we_c = 1'b0;
`endif
    end

    // Post-edge view of one entry as {valid, data}: w1, then w0, then storage.
    function automatic logic [DATA_WIDTH:0] rd_next(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH:0] res;
        res = {valid[a] & ~bus.clear, mem[a]};
        if (w0_we_c && (bus.w0addr == a)) res = {1'b1, bus.w0data};
        if (w1_we_c && (bus.w1addr == a)) res = {1'b1, bus.w1data};
`ifdef REG_FILE_ZERO_REG_EN
        if (a == ADDR_WIDTH'(0)) res = {1'b1, DATA_WIDTH'(0)};
`endif
        return res;
    endfunction

    always_comb begin
        r0_next_c = rd_next(bus.r0addr);
        r1_next_c = rd_next(bus.r1addr);
    end

    // Storage and valid bits; the later w1 assignment overrides w0 on collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            valid <= '0;
        end else begin
            if (bus.clear) valid <= '0;
            if (w0_we_c) begin
                mem[bus.w0addr]   <= bus.w0data;
                valid[bus.w0addr] <= 1'b1;
            end
            if (w1_we_c) begin
                mem[bus.w1addr]   <= bus.w1data;
                valid[bus.w1addr] <= 1'b1;
            end
        end
    end

    // Registered read ports; hold when disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.r0data  <= '0;
            bus.r0valid <= 1'b0;
            bus.r1data  <= '0;
            bus.r1valid <= 1'b0;
        end else begin
            if (bus.r0en) begin
                bus.r0valid <= r0_next_c[DATA_WIDTH];
                bus.r0data  <= r0_next_c[DATA_WIDTH-1:0];
            end
            if (bus.r1en) begin
                bus.r1valid <= r1_next_c[DATA_WIDTH];
                bus.r1data  <= r1_next_c[DATA_WIDTH-1:0];
            end
        end
    end
endmodule

// File: doc/reg_file_dual_wr.md
Name: reg_file_dual_wr

Overview:
- Parametrised successor to the 64x32 register file: generalised data width and depth, adds a second write port, registered reads with write-through forwarding, and per-entry valid tracking.
- Serves as the operand store of the datapath. Two read ports feed the execute stage; two write ports take writeback and load-return.
- Every read result carries a valid bit, so downstream logic can tell written entries from stale ones.

Parameters:
- DATA_WIDTH, 64, width of each entry and of every data port.
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  one-cycle pulse; clears all valid bits; data array is not touched.
- r0en  input  1  read port 0 enable.
- r0addr  input  ADDR_WIDTH  read port 0 address.
- r0data  output  DATA_WIDTH  registered read port 0 data.
- r0valid  output  1  registered valid bit of the entry read on port 0.
- r1en  input  1  read port 1 enable.
- r1addr  input  ADDR_WIDTH  read port 1 address.
- r1data  output  DATA_WIDTH  registered read port 1 data.
- r1valid  output  1  registered valid bit of the entry read on port 1.
- w0ena  input  1  write port 0 enable.
- w0addr  input  ADDR_WIDTH  write port 0 address.
- w0data  input  DATA_WIDTH  write port 0 data.
- w1ena  input  1  write port 1 enable.
- w1addr  input  ADDR_WIDTH  write port 1 address.
- w1data  input  DATA_WIDTH  write port 1 data.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: on a rising edge with reset=1:
  - all DEPTH entries go to 0 and all valid bits go to 0;
  - r0data, r1data, r0valid and r1valid go to 0;
  - reset overrides clear, writes and reads in the same cycle.
- Writes:
  - An enabled write port updates mem[addr] and sets valid[addr]=1 on the rising edge.
  - w0ena and w1ena asserted to the same address in one cycle: w1 wins (data and valid); w0's write is dropped.
- Clear:
  - clear=1 sets all valid bits to 0 on the edge.
  - A write in the same cycle as clear leaves its target entry valid=1 and writes the data. The write has priority over clear for that entry only.
- Reads:
  - Latency 1 cycle. On an edge with rXen=1, rXdata/rXvalid load the post-edge state of entry rXaddr, i.e. write-through forwarding.
  - If a write targets rXaddr in the same cycle, the read returns the new data with valid=1, using the w1-over-w0 priority.
  - If clear is asserted and no write targets rXaddr that cycle, rXvalid loads 0 and rXdata loads the stored data.
- Read disabled: with rXen=0, rXdata and rXvalid hold their previous values.
- Port independence: both read ports may use the same address in one cycle; both return identical results.
- Width rules: addresses are unsigned; no wrap-around, every address in 0..DEPTH-1 is legal. Data is stored and returned unmodified.
- Reset mid-operation: any write presented in the reset cycle is lost. The first write accepted is the one on the edge after reset deasserts.

Optional Feature:
- Macro: REG_FILE_ZERO_REG_EN.
- Defined:
  - entry 0 is hardwired: writes to address 0 are ignored, and valid[0] is never set by a write;
  - reads of address 0 always return data 0 with valid=1, including the same cycle as clear and a write to 0;
  - a dual write where w1 targets 0 and w0 targets another address still commits w0.
- Undefined: entry 0 behaves like every other entry.

Test Plan:
- Reset behaviour: hold reset 5 cycles, then read 0x05 and 0x10 -> r0data=0, r0valid=0, r1data=0, r1valid=0.
- Basic write/read-back: write 0xa5a5 to 0x10 via w0, then 0xf0f0 to 0x1f via w1. Next cycle read r0addr=0x1f, r1addr=0x10 -> one cycle later r0data=0xf0f0, r1data=0xa5a5, both valid=1.
- Dual-write collision with forwarding: same cycle w0 writes 0x1111 to 0x07, w1 writes 0x2222 to 0x07, and r0addr=0x07 with r0en=1 -> r0data=0x2222, r0valid=1. A later read of 0x07 also returns 0x2222.
- Clear with concurrent write: entries 0x03 and 0x04 valid. Pulse clear while w0 writes 0xbeef to 0x04 -> read 0x03 gives valid=0 with old data; read 0x04 gives 0xbeef, valid=1.
- Read hold: r0en=0 while 0x10 is overwritten with 0x5a5a -> r0data stays 0xa5a5. Raising r0en returns 0x5a5a after one cycle.
- With REG_FILE_ZERO_REG_EN: write 0xffff to 0x00, then read 0x00 -> r0data=0, r0valid=1.
